// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline control unit.
//
// Merges the EX-stage jump request, divider busy, bus-arbiter hold and CLINT
// interrupt redirect into one stall signal, one flush level and one PC
// redirect. A redirect that arrives while the pipeline is frozen is parked in
// a single pending slot and issued in the first unfrozen cycle. Every redirect
// is followed by FLUSH_CYCLES unstalled cycles of Hold_Id, which cover fetch
// latency.
//
// Parameters:
//   FLUSH_CYCLES   extra Hold_Id cycles after a redirect cycle (0..7)
//   STALL_TIMEOUT  consecutive stall cycles before the watchdog pulse (1..255)
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous active-low reset
//   ex_jump_flag_i   EX resolved a taken jump/branch
//   ex_jump_addr_i   jump target
//   div_busy_i       divider occupies EX
//   rib_hold_i       bus arbiter withholds the core
//   int_assert_i     one-cycle interrupt redirect pulse
//   int_addr_i       trap / return target
//   stall_flag_o     freeze PC, IF/ID and ID/EX
//   hold_flag_o      flush level (0 none, 1 pc, 2 if, 3 id)
//   jump_flag_o      redirect PC this cycle
//   jump_addr_o      redirect target (0 when no redirect)
//   stall_timeout_o  one-cycle watchdog pulse
//   dbg_state_o      FSM state for observation: 0 RUN, 1 FLUSH
//
// Every output is combinational and is forced to 0 while rst is low.

module pipe_ctrl #(
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_jump_flag_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        div_busy_i,
    input  logic        rib_hold_i,
    input  logic        int_assert_i,
    input  logic [31:0] int_addr_i,
    output logic        stall_flag_o,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        stall_timeout_o,
    output logic        dbg_state_o
);

    // Flush levels. Hold_Pc (1) and Hold_If (2) exist in the encoding but
    // this unit only ever drives none or a full flush through ID.
    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [7:0] STALL_MAX  = 8'(STALL_TIMEOUT);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  flush_cnt, flush_cnt_nx;
    logic        pend_v, pend_v_nx;
    logic        pend_int, pend_int_nx;
    logic [31:0] pend_addr, pend_addr_nx;
    logic [7:0]  stall_cnt, stall_cnt_nx;

    logic        stall_src;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic [2:0]  hold_d;
    logic        timeout_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            flush_cnt <= 3'd0;
            pend_v    <= 1'b0;
            pend_int  <= 1'b0;
            pend_addr <= 32'd0;
            stall_cnt <= 8'd0;
        end else begin
            state     <= state_nx;
            flush_cnt <= flush_cnt_nx;
            pend_v    <= pend_v_nx;
            pend_int  <= pend_int_nx;
            pend_addr <= pend_addr_nx;
            stall_cnt <= stall_cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        flush_cnt_nx = flush_cnt;
        pend_v_nx    = pend_v;
        pend_int_nx  = pend_int;
        pend_addr_nx = pend_addr;
        hold_d       = HOLD_NONE;

        stall_src = div_busy_i | rib_hold_i;
        redirect  = !stall_src && (pend_v || int_assert_i || ex_jump_flag_i);

        // A parked request is older than anything arriving now, so it wins.
        if (pend_v)
            redirect_addr = pend_addr;
        else if (int_assert_i)
            redirect_addr = int_addr_i;
        else
            redirect_addr = ex_jump_addr_i;

        if (stall_src) begin
            // Frozen: park requests, keep the FSM and flush count where they
            // are. An interrupt takes the slot unconditionally; a jump only
            // takes it when no interrupt already sits there.
            if (int_assert_i) begin
                pend_v_nx    = 1'b1;
                pend_int_nx  = 1'b1;
                pend_addr_nx = int_addr_i;
            end else if (ex_jump_flag_i && !(pend_v && pend_int)) begin
                pend_v_nx    = 1'b1;
                pend_int_nx  = 1'b0;
                pend_addr_nx = ex_jump_addr_i;
            end
        end else if (redirect) begin
            // Redirect cycle, in RUN or FLUSH alike: the window restarts.
            hold_d      = HOLD_ID;
            pend_v_nx   = 1'b0;
            pend_int_nx = 1'b0;
            if (FLUSH_CYCLES == 0) begin
                state_nx     = ST_RUN;
                flush_cnt_nx = 3'd0;
            end else begin
                state_nx     = ST_FLUSH;
                flush_cnt_nx = FLUSH_LOAD;
            end
        end else begin
            case (state)
                ST_FLUSH: begin
                    hold_d = HOLD_ID;
                    if (flush_cnt <= 3'd1) begin
                        state_nx     = ST_RUN;
                        flush_cnt_nx = 3'd0;
                    end else begin
                        flush_cnt_nx = flush_cnt - 3'd1;
                    end
                end
                default: begin
                    hold_d = HOLD_NONE;
                end
            endcase
        end
    end

    // Watchdog: counts consecutive stalled cycles and pulses on the cycle
    // whose count reaches STALL_MAX; saturation keeps it from pulsing again.
    always_comb begin
        if (!stall_src)
            stall_cnt_nx = 8'd0;
        else if (stall_cnt == STALL_MAX)
            stall_cnt_nx = stall_cnt;
        else
            stall_cnt_nx = stall_cnt + 8'd1;
        timeout_d = stall_src && (stall_cnt == STALL_MAX - 8'd1);
    end

    always_comb begin
        stall_flag_o    = rst & stall_src;
        jump_flag_o     = rst & redirect;
        jump_addr_o     = (rst && redirect) ? redirect_addr : 32'd0;
        hold_flag_o     = rst ? hold_d : HOLD_NONE;
        stall_timeout_o = rst & timeout_d;
        dbg_state_o     = rst & (state == ST_FLUSH);
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit driving the stall and flush inputs of the IF/ID and ID/EX pipeline registers and the PC redirect. It merges EX-stage jump requests, divider busy, bus-arbitration hold and CLINT interrupt redirects into one `stall_flag_o`, a `hold_flag_o` flush level, and one PC redirect. Redirects raised while the pipeline is frozen are queued, not dropped, and each redirect is followed by a fixed flush window that covers fetch latency.

## Interface
- `FLUSH_CYCLES`, 1: extra flush cycles after a redirect cycle, range 0..7.
- `STALL_TIMEOUT`, 255: consecutive stall cycles before `stall_timeout_o` pulses, range 1..255.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `ex_jump_flag_i`  in  1  EX resolved a taken jump or branch.
- `ex_jump_addr_i`  in  32  jump target.
- `div_busy_i`  in  1  divider occupies EX.
- `rib_hold_i`  in  1  bus arbiter withholds the core.
- `int_assert_i`  in  1  one-cycle interrupt redirect pulse from CLINT.
- `int_addr_i`  in  32  trap or return target.
- `stall_flag_o`  out  1  freeze PC, IF/ID and ID/EX (hold current contents).
- `hold_flag_o`  out  3  flush level: Hold_None=0, Hold_Pc=1, Hold_If=2, Hold_Id=3.
- `jump_flag_o`  out  1  redirect PC this cycle.
- `jump_addr_o`  out  32  redirect target.
- `stall_timeout_o`  out  1  one-cycle watchdog pulse.

## Operation
- Stall source: `stall_src = div_busy_i | rib_hold_i`. The stall outputs are combinational: `stall_flag_o = stall_src`, in every state.
- Pending register: `pend_v` plus 32-bit `pend_addr`. A request arriving while `stall_src` is high is latched into it.
  - Interrupt beats jump when both arrive in the same cycle.
  - A later interrupt overwrites a pending jump.
  - A later jump never overwrites a pending interrupt.
  - Interrupt priority is tracked by a `pend_int` bit.
- Redirect cycle. Occurs when `stall_src` is low and any of these holds: `pend_v`, `int_assert_i`, or `ex_jump_flag_i`. Priority in that cycle is pending > interrupt > jump.
  - Outputs: `jump_flag_o=1`, `jump_addr_o` = selected address, `hold_flag_o=Hold_Id`.
  - `pend_v` clears.
  - The FSM enters FLUSH with `flush_cnt=FLUSH_CYCLES`, or stays in RUN if `FLUSH_CYCLES=0`.
- FSM states:
  - RUN: `hold_flag_o=Hold_None` unless this is a redirect cycle.
  - FLUSH: `hold_flag_o=Hold_Id`. `flush_cnt` decrements on each cycle with `stall_src` low and freezes while `stall_src` is high. FLUSH returns to RUN after the cycle in which the count reaches 1.
  - A redirect occurring in FLUSH (for example an interrupt) restarts `flush_cnt`.
- Whenever `stall_src` is high, `jump_flag_o=0` and `hold_flag_o=Hold_None`: the stall always wins over the flush.
- Jump outputs outside a redirect cycle: `jump_flag_o=0`, `jump_addr_o=0`.
- Watchdog: 8-bit `stall_cnt` increments while `stall_src` is high, saturates at `STALL_TIMEOUT`, and clears when `stall_src` is low. `stall_timeout_o` pulses for one cycle on the transition to `STALL_TIMEOUT`.
- Reset (asynchronous, any time, including mid-stall or mid-flush):
  - State goes to RUN; `pend_v`, `pend_int`, `pend_addr`, `flush_cnt` and `stall_cnt` clear.
  - All outputs are forced to 0 (`hold_flag_o=Hold_None`) while `rst` is low.
  - No queued redirect survives reset.

## Timing
- Unqueued redirect: zero latency. `jump_flag_o` is high in the same cycle as `ex_jump_flag_i` or `int_assert_i`.
- Queued redirect: issued in the first cycle with `stall_src` low, combinational from `pend_*`. Latency equals the remaining stall length.
- Stall: zero latency in both directions.
- Flush window: redirect cycle plus `FLUSH_CYCLES` unstalled cycles of `Hold_Id`.
- First cycle after reset release: RUN, outputs driven from inputs.
- All state updates occur on `posedge clk`.

## Test plan
- Jump `0x0000_0100` with `FLUSH_CYCLES=1` and no stall -> `jump_flag_o=1` and `jump_addr_o=0x100` in cycle N; `hold_flag_o=3` in cycles N and N+1; `hold_flag_o=0` in N+2.
- `div_busy_i` high for 5 cycles -> `stall_flag_o=1` for exactly those 5 cycles; `hold_flag_o=0`; no redirect.
- `int_assert_i` pulse with `int_addr_i=0x8000_0004` in the 2nd cycle of a 4-cycle `rib_hold_i` -> no redirect during the hold; in the cycle the hold drops, `jump_flag_o=1` and `jump_addr_o=0x8000_0004`, then the flush window.
- Jump to `0x200` and interrupt to `0x300` in the same unstalled cycle -> `jump_addr_o=0x300`; the jump is dropped.
- `STALL_TIMEOUT=4`, stall held for 6 cycles -> `stall_timeout_o` pulses once, in the 4th stalled cycle.
- `rst` asserted mid-stall with a pending interrupt -> outputs 0 immediately. After release with no stall, no redirect is issued.
